alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one PE ALU among NUM_REQ requesters: PE decoder, CGRA neighbour ports, etc.
//  Requesters are served round-robin. Grant, operand latch, execute, response are
//  sequenced by an FSM. Multi-cycle ops (mul/div) finish on the ALU's complete flag.
//  Sits between the requesters and the alu instance, inside the RISC-V PE.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  DATA_W   32  operand/result width
//  SEL_W    5   ALU opcode width (matches ALU_Sel)
//  TIMEOUT  64  max EXEC cycles before error (only with ALU_ARB_TIMEOUT_EN)
// PORTS
//  clk           in   1               rising-edge clock
//  rst_n         in   1               async active-low reset
//  req_valid     in   NUM_REQ         per-requester op request
//  req_ready     out  NUM_REQ         one-hot accept pulse
//  req_a         in   NUM_REQ*DATA_W  operand A, slice i = requester i
//  req_b         in   NUM_REQ*DATA_W  operand B
//  req_sel       in   NUM_REQ*SEL_W   ALU opcode
//  rsp_valid     out  NUM_REQ         one-hot response valid
//  rsp_ready     in   NUM_REQ         per-requester response accept
//  rsp_data      out  DATA_W          result (shared bus, qualified by rsp_valid)
//  rsp_zero      out  1               ALU Zero flag of the result
//  rsp_err       out  1               op timed out; rsp_data = 0
//  alu_a/alu_b   out  DATA_W          to ALU A/B
//  alu_sel       out  SEL_W           to ALU_Sel
//  alu_out       in   DATA_W          from ALU_Out
//  alu_zero      in   1               from Zero
//  alu_complete  in   1               from ALUcomplete
//  busy          out  1               FSM not in IDLE
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0: req_ready, rsp_*, alu_*, busy. last_grant=NUM_REQ-1,
//  so the first grant goes to req 0. Async assert, clean release on the clk edge.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: if any req_valid, g = first set bit searching from last_grant+1 with wrap.
//   - req_ready[g]=1 for exactly that cycle. Latch req_a/b/sel slice g.
//   - Next state EXEC. No req_valid: stay IDLE, req_ready=0.
//  EXEC: alu_a/b/sel driven from latched regs, stable for the whole state. busy=1.
//   - alu_complete ignored in the first EXEC cycle, because the ALU may hold a stale flag.
//   - From the 2nd cycle on: alu_complete=1 -> capture alu_out/alu_zero, go to RESP.
//  RESP: rsp_valid[g]=1; rsp_data/zero/err held until rsp_ready[g]=1.
//   - Then last_grant=g, rsp_valid=0, go to IDLE.
//   - rsp_ready of non-granted requesters ignored.
//  Latency: accept->rsp_valid = 2 + ALU cycles. Minimum issue interval is 4 cycles.
//  req_valid deasserted before accept: no op, no error. req_ready never asserts outside IDLE.
//  Requests held during EXEC/RESP wait; no requester starves (max wait NUM_REQ-1 grants).
//  Simultaneous rsp_ready and new req_valid: handshake completes first; the new request
//  is arbitrated in the following IDLE cycle.
//  alu_* keep the last op's values in IDLE/RESP; alu_* return to 0 only on reset.
//  Reset mid-op: op aborted, no response; requesters reissue.
// CONFIGURATION
//  ALU_ARB_TIMEOUT_EN defined:
//   - EXEC counter counts 1..TIMEOUT. If alu_complete not seen by cycle TIMEOUT:
//     rsp_err=1, rsp_data=0, rsp_zero=0, go to RESP.
//   - Counter clears on EXEC entry.
//  Not defined: no counter. EXEC waits indefinitely. rsp_err tied 0.
// TESTING
//  1 Req0 A=5 B=3 sel=00000, complete 1 cyc after EXEC entry.
//    -> rsp_valid=0001, rsp_data=8, zero=0.
//  2 Reqs 0..3 all valid continuously, each sel=00001 A=5 B=5.
//    -> grants 0,1,2,3,0; each rsp_data=0, zero=1.
//  3 After grant to 1, req1 and req2 valid.
//    -> req2 granted first (round-robin), then req1.
//  4 rsp_ready[g] held 0 for 10 cycles.
//    -> rsp_valid/rsp_data stable; req_ready stays 0 for others; no new grant.
//  5 With ALU_ARB_TIMEOUT_EN, TIMEOUT=8, alu_complete stuck 0.
//    -> RESP after 8 EXEC cycles, rsp_err=1, rsp_data=0.
//  6 rst_n low during EXEC of a mul (A=2 B=3).
//    -> all outputs 0 immediately; after release no rsp_valid; next grant goes to req0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of a single PE ALU among NUM_REQ requesters.
// An IDLE -> EXEC -> RESP FSM sequences grant, operand latch, execute and response.
// Optional feature macro ALU_ARB_TIMEOUT_EN: bounds EXEC at TIMEOUT cycles and reports
// rsp_err with a zero result; without it EXEC waits for alu_complete indefinitely.
`timescale 1ns/1ps
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_a,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0][SEL_W-1:0]  req_sel,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [DATA_W-1:0]              rsp_data,
    output logic                           rsp_zero,
    output logic                           rsp_err,
    output logic [DATA_W-1:0]              alu_a,
    output logic [DATA_W-1:0]              alu_b,
    output logic [SEL_W-1:0]               alu_sel,
    input  logic [DATA_W-1:0]              alu_out,
    input  logic                           alu_zero,
    input  logic                           alu_complete,
    output logic                           busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [IDX_W-1:0] last_grant;   // requester served most recently
    logic [IDX_W-1:0] gnt;          // requester owning the current op
    logic [IDX_W-1:0] pick;         // round-robin winner this cycle
    logic [IDX_W-1:0] cand;
    logic             any_req;
    logic             exec_first;   // first EXEC cycle: ALU may still show a stale complete

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2) begin : g_param_check
        $error("alu_share_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 2");
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] exec_cnt;     // 1-based EXEC cycle number
    logic             timed_out;
    assign exec_first = (exec_cnt == CNT_W'(1));
    assign timed_out  = (exec_cnt == CNT_W'(TIMEOUT));
`else
    assign rsp_err = 1'b0;
`endif

    // Round-robin search: first valid requester after last_grant, wrapping around.
    always_comb begin
        pick    = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!any_req && req_valid[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

    // Accept pulse is combinational so it lands in the IDLE cycle that latches the operands;
    // gated by rst_n so every output reads 0 while reset is held.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
        assign req_ready[i] = rst_n && (state == IDLE) && any_req && (pick == IDX_W'(i));
    end

    // Sequencing FSM with registered ALU drive and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            busy       <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
            exec_cnt   <= '0;
            rsp_err    <= 1'b0;
`else
            exec_first <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt     <= pick;
                        alu_a   <= req_a[pick];
                        alu_b   <= req_b[pick];
                        alu_sel <= req_sel[pick];
                        busy    <= 1'b1;
                        state   <= EXEC;
`ifdef ALU_ARB_TIMEOUT_EN
                        exec_cnt   <= CNT_W'(1);
`else
                        exec_first <= 1'b1;
`endif
                    end
                end
                EXEC: begin
`ifdef ALU_ARB_TIMEOUT_EN
                    if (!exec_first && alu_complete) begin
                        rsp_data  <= alu_out;
                        rsp_zero  <= alu_zero;
                        rsp_err   <= 1'b0;
                        rsp_valid <= NUM_REQ'(1) << gnt;
                        state     <= RESP;
                    end else if (timed_out) begin
                        rsp_data  <= '0;
                        rsp_zero  <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= NUM_REQ'(1) << gnt;
                        state     <= RESP;
                    end else begin
                        exec_cnt  <= exec_cnt + CNT_W'(1);
                    end
`else
                    exec_first <= 1'b0;
                    if (!exec_first && alu_complete) begin
                        rsp_data  <= alu_out;
                        rsp_zero  <= alu_zero;
                        rsp_valid <= NUM_REQ'(1) << gnt;
                        state     <= RESP;
                    end
`endif
                end
                RESP: begin
                    // Only the owning requester can close the handshake.
                    if (rsp_ready[gnt]) begin
                        rsp_valid  <= '0;
                        last_grant <= gnt;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios then randomized traffic, checked
// against a transaction-level model (pending set, round-robin pointer, ALU function).
`timescale 1ns/1ps
module tb_alu_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 5;
    localparam int TIMEOUT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic [NUM_REQ-1:0]             req_valid = '0;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_a = '0;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_b = '0;
    logic [NUM_REQ-1:0][SEL_W-1:0]  req_sel = '0;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [NUM_REQ-1:0]             rsp_ready = '0;
    logic [DATA_W-1:0]              rsp_data;
    logic                           rsp_zero, rsp_err;
    logic [DATA_W-1:0]              alu_a, alu_b;
    logic [SEL_W-1:0]               alu_sel;
    logic [DATA_W-1:0]              alu_out = '0;
    logic                           alu_zero = 1'b0;
    logic                           alu_complete = 1'b0;
    logic                           busy;

    alu_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_complete(alu_complete),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who is waiting, with what operands, and who was served last.
    int               ptr;
    bit               pend   [NUM_REQ];
    logic [DATA_W-1:0] op_a  [NUM_REQ];
    logic [DATA_W-1:0] op_b  [NUM_REQ];
    logic [SEL_W-1:0]  op_sel[NUM_REQ];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The bench stands in for the ALU; this is the function it computes.
    function automatic logic [DATA_W-1:0] alu_ref(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                  input logic [SEL_W-1:0] sel);
        case (sel)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a * b;
            5'd3:    return a & b;
            5'd4:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic int rr_pick();
        for (int k = 1; k <= NUM_REQ; k++)
            if (pend[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = pend[i];
            req_a[i]     = op_a[i];
            req_b[i]     = op_b[i];
            req_sel[i]   = op_sel[i];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b0; op_a[i] = '0; op_b[i] = '0; op_sel[i] = '0;
        end
    endtask

    // One full transaction. Entered just after a clock edge with the DUT in IDLE; returns
    // just after the handshake edge. d = ALU cycles after the first EXEC cycle (>= 1),
    // hold = RESP cycles with rsp_ready[g] low, keep = requester stays valid after accept.
    task automatic run_txn(input int d, input int hold, input bit keep, output int g);
        logic [DATA_W-1:0] exp;
        g   = rr_pick();
        exp = alu_ref(op_a[g], op_b[g], op_sel[g]);
        drive_reqs();
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("grant", 64'(req_ready), 64'(onehot(g)));
        @(posedge clk); #1;
        if (!keep) begin pend[g] = 1'b0; drive_reqs(); end
        alu_complete = 1'($urandom);          // stale flag, must be ignored
        alu_out      = $urandom;
        alu_zero     = 1'($urandom);
        @(negedge clk);
        chk("exec_busy", 64'(busy), 64'(1));
        chk("exec_alu_a", 64'(alu_a), 64'(op_a[g]));
        chk("exec_alu_b", 64'(alu_b), 64'(op_b[g]));
        chk("exec_alu_sel", 64'(alu_sel), 64'(op_sel[g]));
        chk("exec_no_ready", 64'(req_ready), 64'(0));
        chk("exec_rsp_valid", 64'(rsp_valid), 64'(0));
        for (int c = 2; c <= d + 1; c++) begin
            @(posedge clk); #1;
            alu_complete = (c == d + 1);
            alu_out      = (c == d + 1) ? exp : DATA_W'($urandom);
            alu_zero     = (c == d + 1) ? (exp == '0) : 1'($urandom);
            @(negedge clk);
            chk("exec_wait_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("exec_alu_a_stable", 64'(alu_a), 64'(op_a[g]));
        end
        @(posedge clk); #1;
        alu_complete = 1'b0;
        alu_out      = $urandom;
        for (int h = 0; h <= hold; h++) begin
            rsp_ready = (NUM_REQ'($urandom) & ~onehot(g)) | ((h == hold) ? onehot(g) : '0);
            @(negedge clk);
            chk("resp_valid", 64'(rsp_valid), 64'(onehot(g)));
            chk("resp_data", 64'(rsp_data), 64'(exp));
            chk("resp_zero", 64'(rsp_zero), 64'(exp == '0));
            chk("resp_err", 64'(rsp_err), 64'(0));
            chk("resp_no_ready", 64'(req_ready), 64'(0));
            chk("resp_busy", 64'(busy), 64'(1));
            @(posedge clk); #1;
        end
        rsp_ready = '0;
        ptr = g;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_data"},  64'(rsp_data), 64'(0));
        chk({tag, "_rsp_zero"},  64'(rsp_zero), 64'(0));
        chk({tag, "_rsp_err"},   64'(rsp_err), 64'(0));
        chk({tag, "_alu_a"},     64'(alu_a), 64'(0));
        chk({tag, "_alu_b"},     64'(alu_b), 64'(0));
        chk({tag, "_alu_sel"},   64'(alu_sel), 64'(0));
        chk({tag, "_busy"},      64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int exp_seq[5];
        exp_seq = '{0, 1, 2, 3, 0};
        clear_model();
        ptr = NUM_REQ - 1;

        // Reset state, with every requester asserting valid during reset.
        #1 rst_n = 1'b0;
        req_valid = '1;
        @(negedge clk);
        check_all_zero("reset");
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: req0 5+3, one ALU cycle after the first EXEC cycle.
        op_a[0] = 32'd5; op_b[0] = 32'd3; op_sel[0] = 5'd0; pend[0] = 1'b1;
        run_txn(1, 0, 1'b0, g);
        chk("t1_grant", 64'(g), 64'(0));

        // Test 3: grant req1, then req1+req2 valid -> req2 before req1.
        op_a[1] = 32'h10; op_b[1] = 32'h4; op_sel[1] = 5'd1; pend[1] = 1'b1;
        run_txn(2, 0, 1'b0, g);
        chk("t3_first", 64'(g), 64'(1));
        op_a[2] = 32'h7; op_b[2] = 32'h6; op_sel[2] = 5'd2; pend[2] = 1'b1; pend[1] = 1'b1;
        run_txn(1, 0, 1'b0, g);
        chk("t3_rr_req2", 64'(g), 64'(2));
        run_txn(3, 1, 1'b0, g);
        chk("t3_rr_req1", 64'(g), 64'(1));

        // Test 4: response held 10 cycles while others wait.
        op_a[2] = 32'hF0; op_b[2] = 32'h0F; op_sel[2] = 5'd4; pend[2] = 1'b1;
        op_a[3] = 32'h3;  op_b[3] = 32'h3;  op_sel[3] = 5'd5; pend[3] = 1'b1;
        op_a[0] = 32'h9;  op_b[0] = 32'h2;  op_sel[0] = 5'd3; pend[0] = 1'b1;
        run_txn(1, 10, 1'b0, g);
        chk("t4_hold_grant", 64'(g), 64'(2));
        run_txn(1, 0, 1'b0, g);
        chk("t4_next", 64'(g), 64'(3));
        run_txn(2, 2, 1'b0, g);
        chk("t4_wrap", 64'(g), 64'(0));

`ifdef ALU_ARB_TIMEOUT_EN
        // Test 5: ALU never completes -> error response after TIMEOUT EXEC cycles.
        op_a[1] = 32'd7; op_b[1] = 32'd9; op_sel[1] = 5'd2; pend[1] = 1'b1;
        drive_reqs();
        @(negedge clk);
        chk("t5_grant", 64'(req_ready), 64'(onehot(1)));
        @(posedge clk); #1;
        pend[1] = 1'b0; drive_reqs();
        alu_complete = 1'b0; alu_out = 32'hDEAD; alu_zero = 1'b1;
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(negedge clk);
            chk("t5_exec_rsp_valid", 64'(rsp_valid), 64'(0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t5_rsp_valid", 64'(rsp_valid), 64'(onehot(1)));
        chk("t5_rsp_err", 64'(rsp_err), 64'(1));
        chk("t5_rsp_data", 64'(rsp_data), 64'(0));
        chk("t5_rsp_zero", 64'(rsp_zero), 64'(0));
        rsp_ready = onehot(1);
        @(posedge clk); #1;
        rsp_ready = '0; alu_zero = 1'b0;
        ptr = 1;
`endif

        // Test 6: reset during EXEC of a mul from req2.
        op_a[2] = 32'd2; op_b[2] = 32'd3; op_sel[2] = 5'd2; pend[2] = 1'b1;
        drive_reqs();
        @(negedge clk);
        chk("t6_grant", 64'(req_ready), 64'(onehot(2)));
        @(posedge clk); #1;
        pend[2] = 1'b0; drive_reqs();
        alu_complete = 1'b0;
        @(negedge clk);
        chk("t6_exec_busy", 64'(busy), 64'(1));
        chk("t6_exec_alu_a", 64'(alu_a), 64'(2));
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        alu_complete = 1'b1; alu_out = 32'd6;
        @(negedge clk);
        rst_n = 1'b1;
        ptr = NUM_REQ - 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_no_rsp", 64'(rsp_valid), 64'(0));
            chk("t6_idle", 64'(busy), 64'(0));
        end
        @(posedge clk); #1;
        alu_complete = 1'b0;

        // Test 2: all requesters valid continuously, sub 5-5 -> 0,1,2,3,0, zero result.
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = 32'd5; op_b[i] = 32'd5; op_sel[i] = 5'd1; pend[i] = 1'b1;
        end
        for (int n = 0; n < 5; n++) begin
            run_txn(1 + n % 2, 0, 1'b1, g);
            chk("t2_grant", 64'(g), 64'(exp_seq[n]));
        end
        clear_model();
        drive_reqs();

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i]   = 1'b1;
                    op_a[i]   = $urandom;
                    op_b[i]   = ($urandom % 4 == 0) ? op_a[i] : DATA_W'($urandom);
                    op_sel[i] = SEL_W'($urandom % 6);
                end
                any |= pend[i];
            end
            if (!any) begin
                drive_reqs();
                @(negedge clk);
                chk("rand_idle_ready", 64'(req_ready), 64'(0));
                chk("rand_idle_busy", 64'(busy), 64'(0));
                @(posedge clk); #1;
            end else begin
                run_txn($urandom_range(1, 4), $urandom_range(0, 3), 1'b0, g);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
